// File: rtl/state_reg_pkg.sv
// state_reg_pkg: FSM encoding, clog2 and parameter legality check for state_reg_iter
package state_reg_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit params_ok(input int rounds, input int rpc);
    return rpc > 0 && rpc <= rounds && rounds % rpc == 0;
  endfunction
endpackage

// File: rtl/state_reg_rnd_cnt.sv
// state_reg_rnd_cnt: round index counter stepping by RPC with last-round flag
module state_reg_rnd_cnt #(
  parameter int ROUNDS = 40,
  parameter int RPC = 1,
  parameter int RCW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           step,
  output logic [RCW-1:0] cnt,
  output logic           last
);
  localparam logic [RCW-1:0] LAST_IDX = RCW'(ROUNDS - RPC);
  localparam logic [RCW-1:0] STEP_SZ = RCW'(RPC);
  logic [RCW-1:0] cnt_d, cnt_q;
  always_comb cnt_d = (clr || (step && last)) ? '0 : step ? cnt_q + STEP_SZ : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
  assign last = cnt_q == LAST_IDX;
endmodule

// File: rtl/state_reg_iter.sv
// state_reg_iter: cipher state register with clear/load/absorb and round sequencer
module state_reg_iter
  import state_reg_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter int ROUNDS = 40,
  parameter int RPC = 1,
  localparam int RCW = clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             absorb,
  input  logic             start,
  input  logic [WIDTH-1:0] si,
  input  logic [WIDTH-1:0] skinnys,
  output logic [WIDTH-1:0] so,
  output logic [RCW-1:0]   rnd,
  output logic             busy,
  output logic             done
);
  if (!params_ok(ROUNDS, RPC)) begin : g_bad_params
    $error("state_reg_iter: ROUNDS must be a multiple of RPC and RPC <= ROUNDS");
  end
  state_t state_d, state_q;
  logic [WIDTH-1:0] so_d, so_q;
  logic done_d, done_q, last;
  state_reg_rnd_cnt #(.ROUNDS(ROUNDS), .RPC(RPC), .RCW(RCW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state_q == IDLE),
    .step(state_q == RUN),
    .cnt(rnd),
    .last(last)
  );
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    so_d = clr ? INIT_VALUE : load ? si : absorb ? so_q ^ si : so_q;
    if (state_q == RUN) begin
      so_d = skinnys;
      state_d = last ? IDLE : RUN;
      done_d = last;
    end else if (start) begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    so_q <= rst ? INIT_VALUE : so_d;
    done_q <= rst ? 1'b0 : done_d;
  end
  assign so = so_q;
  assign busy = state_q == RUN;
  assign done = done_q;
endmodule
